// File: rtl/fp_mul_seq.sv
// Iterative floating-point multiplier: radix-4 Booth with one partial product per
// cycle, round-to-nearest-even, subnormal inputs treated as zero, results flushed to zero.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] product,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int S  = MAN_W + 1;
    localparam int P  = 2 * S;
    localparam int N  = (MAN_W + 3) / 2;
    localparam int MW = 2 * N + 1;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Handshake: start is sampled only in IDLE; busy covers UNPACK..ROUND;
    // done is a one-cycle pulse in DONE, never overlapping busy.
    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]     a_q, b_q;
    logic [EW-1:0]    exp_q;
    logic [P-1:0]     mcand, acc, pp, norm;
    logic [MW-1:0]    mult;
    logic [CW-1:0]    cnt;
    logic [S-1:0]     sig_q;
    logic             guard_q, round_q, sticky_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             sign, inf_zero, nan_res, special;
    logic [W-1:0]     spec_product;
    logic [3:0]       spec_flags;

    assign ea       = a_q[W-2:MAN_W];
    assign eb       = b_q[W-2:MAN_W];
    assign fa       = a_q[MAN_W-1:0];
    assign fb       = b_q[MAN_W-1:0];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (&ea) && (fa == '0);
    assign b_inf    = (&eb) && (fb == '0);
    assign a_nan    = (&ea) && (fa != '0);
    assign b_nan    = (&eb) && (fb != '0);
    assign a_snan   = a_nan && !fa[MAN_W-1];
    assign b_snan   = b_nan && !fb[MAN_W-1];
    assign sign     = a_q[W-1] ^ b_q[W-1];
    assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
    assign nan_res  = a_nan || b_nan || inf_zero;
    assign special  = nan_res || a_inf || b_inf || a_zero || b_zero;

    always_comb begin
        spec_product = {sign, {(W-1){1'b0}}};
        spec_flags   = 4'b0000;
        if (nan_res) begin
            spec_product = QNAN;
            spec_flags   = {a_snan || b_snan || inf_zero, 3'b000};
        end else if (a_inf || b_inf) begin
            spec_product = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Booth digit from multiplier bits {2i+1, 2i, 2i-1}; negatives wrap modulo 2^P.
    always_comb begin
        pp = '0;
        case (mult[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    assign norm = acc[P-1] ? acc : (acc << 1);

    logic          inc, carry, inexact;
    logic [S:0]    sig_inc;
    logic [S-1:0]  sig_fin;
    logic [EW-1:0] exp_rnd;
    logic [W-1:0]  rnd_product;
    logic [3:0]    rnd_flags;

    always_comb begin
        inc         = guard_q & (round_q | sticky_q | sig_q[0]);
        sig_inc     = {1'b0, sig_q} + {{S{1'b0}}, inc};
        carry       = sig_inc[S];
        sig_fin     = carry ? sig_inc[S:1] : sig_inc[S-1:0];
        exp_rnd     = exp_q + {{(EW-1){1'b0}}, carry};
        inexact     = guard_q | round_q | sticky_q;
        rnd_product = {sign, exp_rnd[EXP_W-1:0], sig_fin[MAN_W-1:0]};
        rnd_flags   = {3'b000, inexact};
        if (!exp_rnd[EW-1] && (exp_rnd >= EXP_TOP)) begin
            rnd_product = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags   = 4'b0101;
        end else if (exp_rnd[EW-1] || (exp_rnd == '0)) begin
            rnd_product = {sign, {(W-1){1'b0}}};
            rnd_flags   = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  begin busy = 1'b1; state_nx = special ? DONE : MUL; end
            MUL:     begin busy = 1'b1; if (cnt == CW'(N - 1)) state_nx = NORM; end
            NORM:    begin busy = 1'b1; state_nx = ROUND; end
            ROUND:   begin busy = 1'b1; state_nx = DONE; end
            DONE:    begin done = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            exp_q    <= '0;
            mcand    <= '0;
            mult     <= '0;
            acc      <= '0;
            cnt      <= '0;
            sig_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            product  <= '0;
            flags    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q <= a;
                    b_q <= b;
                end
                UNPACK: begin
                    exp_q <= {2'b00, ea} + {2'b00, eb} - BIAS;
                    mcand <= {{S{1'b0}}, 1'b1, fa};
                    mult  <= {{(MW-S-1){1'b0}}, 1'b1, fb, 1'b0};
                    acc   <= '0;
                    cnt   <= '0;
                    if (special) begin
                        product <= spec_product;
                        flags   <= spec_flags;
                    end
                end
                MUL: begin
                    acc   <= acc + pp;
                    mcand <= mcand << 2;
                    mult  <= mult >> 2;
                    cnt   <= cnt + CW'(1);
                end
                NORM: begin
                    sig_q    <= norm[P-1:S];
                    guard_q  <= norm[S-1];
                    round_q  <= norm[S-2];
                    sticky_q <= |norm[S-3:0];
                    exp_q    <= exp_q + {{(EW-1){1'b0}}, acc[P-1]};
                end
                ROUND: begin
                    product <= rnd_product;
                    flags   <= rnd_flags;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: FP32 and 5/10-bit instances, directed vectors plus
// random operands checked against an arithmetic reference model.
module tb_fp_mul_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, busy32, done32;
    logic [31:0] a32, b32, product32;
    logic [3:0]  flags32;
    logic        start16, busy16, done16;
    logic [15:0] a16, b16, product16;
    logic [3:0]  flags16;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(product32), .flags(flags32)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(product16), .flags(flags16)
    );

    // Reference: exact integer product of significands, then RNE by comparing the
    // discarded remainder against one half ulp.
    function automatic void ref_mul(input int e_w, input int m_w,
                                    input longint unsigned x, input longint unsigned y,
                                    output longint unsigned p, output logic [3:0] f,
                                    output bit spec);
        longint unsigned top   = (64'd1 << e_w) - 1;
        longint unsigned fmask = (64'd1 << m_w) - 1;
        longint unsigned ex    = (x >> m_w) & top;
        longint unsigned ey    = (y >> m_w) & top;
        longint unsigned fx    = x & fmask;
        longint unsigned fy    = y & fmask;
        longint unsigned sgn   = ((x ^ y) >> (e_w + m_w)) & 64'd1;
        longint unsigned sbit  = sgn << (e_w + m_w);
        longint unsigned prod, q, rem, half;
        longint e;
        int sh;
        bit x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, snan, iz, inexact;
        x_zero = (ex == 0);
        y_zero = (ey == 0);
        x_inf  = (ex == top) && (fx == 0);
        y_inf  = (ey == top) && (fy == 0);
        x_nan  = (ex == top) && (fx != 0);
        y_nan  = (ey == top) && (fy != 0);
        snan   = (x_nan && (((fx >> (m_w - 1)) & 64'd1) == 0)) ||
                 (y_nan && (((fy >> (m_w - 1)) & 64'd1) == 0));
        iz     = (x_inf && y_zero) || (y_inf && x_zero);
        spec   = 1'b1;
        f      = 4'b0000;
        p      = sbit;
        if (x_nan || y_nan || iz) begin
            p = (top << m_w) | (64'd1 << (m_w - 1));
            f = {snan || iz, 3'b000};
        end else if (x_inf || y_inf) begin
            p = sbit | (top << m_w);
        end else if (x_zero || y_zero) begin
            p = sbit;
        end else begin
            spec = 1'b0;
            e    = longint'(ex) + longint'(ey) - ((longint'(1) << (e_w - 1)) - 1);
            prod = ((64'd1 << m_w) | fx) * ((64'd1 << m_w) | fy);
            sh   = m_w;
            if ((prod >> (2 * m_w + 1)) != 0) begin
                sh = m_w + 1;
                e  = e + 1;
            end
            q       = prod >> sh;
            rem     = prod & ((64'd1 << sh) - 1);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
            if (q == (64'd1 << (m_w + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= longint'(top)) begin
                p = sbit | (top << m_w);
                f = 4'b0101;
            end else if (e <= 0) begin
                p = sbit;
                f = 4'b0011;
            end else begin
                p = sbit | ($unsigned(e) << m_w) | (q & fmask);
                f = {3'b000, inexact};
            end
        end
    endfunction

    function automatic longint unsigned rand_op(input int e_w, input int m_w);
        longint unsigned top  = (64'd1 << e_w) - 1;
        longint unsigned bias = (64'd1 << (e_w - 1)) - 1;
        longint unsigned ex, fx, sg;
        int r;
        r  = $urandom_range(0, 9);
        sg = 64'($urandom_range(0, 1));
        fx = {$urandom, $urandom} & ((64'd1 << m_w) - 1);
        if (r == 0)      ex = 0;
        else if (r == 1) ex = top;
        else if (r < 6)  ex = bias - 4 + 64'($urandom_range(0, 8));
        else             ex = 64'($urandom_range(1, int'(top) - 1));
        if (r == 9) fx = fx & ~((64'd1 << (m_w / 2)) - 1);
        return (sg << (e_w + m_w)) | (ex << m_w) | fx;
    endfunction

    // Issues one operation (the first posedge lets a DONE cycle return to IDLE),
    // scrambles the operand inputs while busy, and reports the cycle of done.
    task automatic run32(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] p, output logic [3:0] f,
                         output int lat, output int busy_bad);
        @(posedge clk); #1;
        start32 = 1'b1; a32 = x; b32 = y;
        @(posedge clk); #1;
        start32  = 1'b0;
        lat      = 1;
        busy_bad = 0;
        while (!done32 && lat < 100) begin
            if (!busy32) busy_bad++;
            a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        if (busy32) busy_bad++;
        p = product32;
        f = flags32;
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] p, output logic [3:0] f,
                         output int lat, output int busy_bad);
        @(posedge clk); #1;
        start16 = 1'b1; a16 = x; b16 = y;
        @(posedge clk); #1;
        start16  = 1'b0;
        lat      = 1;
        busy_bad = 0;
        while (!done16 && lat < 100) begin
            if (!busy16) busy_bad++;
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (busy16) busy_bad++;
        p = product16;
        f = flags16;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy32, done32} !== 2'b00) begin
            n_fail++; $display("FAIL reset32_ctrl busy/done=%b required 00", {busy32, done32});
        end
        n_checks++;
        if ({product32, flags32} !== 36'h0) begin
            n_fail++; $display("FAIL reset32_data product=%h flags=%b required 0", product32, flags32);
        end
        n_checks++;
        if ({busy16, done16} !== 2'b00) begin
            n_fail++; $display("FAIL reset16_ctrl busy/done=%b required 00", {busy16, done16});
        end
        n_checks++;
        if ({product16, flags16} !== 20'h0) begin
            n_fail++; $display("FAIL reset16_data product=%h flags=%b required 0", product16, flags16);
        end
        rst_n = 1'b1;
    endtask

    // Directed FP32 vectors: {a, b, product, flags, done latency}.
    task automatic test_directed32();
        logic [31:0] va[11] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                                32'h00800000, 32'h80800000, 32'h7F800000, 32'hFF800000,
                                32'h7FA00000, 32'h7FC00000, 32'h00400000};
        logic [31:0] vb[11] = '{32'h40000000, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000,
                                32'h3F000000, 32'h3F000000, 32'h00000000, 32'h40000000,
                                32'h3F800000, 32'h3F800000, 32'hC0000000};
        logic [31:0] vp[11] = '{32'h40400000, 32'h40000000, 32'h3F800002, 32'h7F800000,
                                32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                                32'h7FC00000, 32'h7FC00000, 32'h80000000};
        logic [3:0]  vf[11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b0011,
                                4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        int          vl[11] = '{17, 17, 17, 17, 17, 17, 2, 2, 2, 2, 2};
        logic [31:0] p;
        logic [3:0]  f;
        int lat, bb;
        for (int i = 0; i < 11; i++) begin
            run32(va[i], vb[i], p, f, lat, bb);
            n_checks++;
            if (p !== vp[i]) begin
                n_fail++; $display("FAIL dir32_product[%0d] got %h required %h", i, p, vp[i]);
            end
            n_checks++;
            if (f !== vf[i]) begin
                n_fail++; $display("FAIL dir32_flags[%0d] got %b required %b", i, f, vf[i]);
            end
            n_checks++;
            if (lat !== vl[i]) begin
                n_fail++; $display("FAIL dir32_latency[%0d] got %0d required %0d", i, lat, vl[i]);
            end
            n_checks++;
            if (bb !== 0) begin
                n_fail++; $display("FAIL dir32_busy[%0d] bad cycles %0d required 0", i, bb);
            end
        end
    endtask

    task automatic test_random32(input int count);
        logic [31:0]     x, y, p;
        logic [3:0]      f, ef;
        longint unsigned ep;
        bit              sp;
        int lat, bb;
        for (int i = 0; i < count; i++) begin
            x = 32'(rand_op(8, 23));
            y = 32'(rand_op(8, 23));
            ref_mul(8, 23, 64'(x), 64'(y), ep, ef, sp);
            run32(x, y, p, f, lat, bb);
            n_checks++;
            if ({p, f} !== {ep[31:0], ef}) begin
                n_fail++;
                $display("FAIL rand32 a=%h b=%h got %h/%b required %h/%b", x, y, p, f, ep[31:0], ef);
            end
            n_checks++;
            if (lat !== (sp ? 2 : 17) || bb !== 0) begin
                n_fail++;
                $display("FAIL rand32_timing a=%h b=%h latency %0d busy_bad %0d required %0d/0",
                         x, y, lat, bb, sp ? 2 : 17);
            end
        end
    endtask

    task automatic test_handshake();
        int lat, n_done;
        @(posedge clk); #1;
        start32 = 1'b1; a32 = 32'h3FC00000; b32 = 32'h40000000;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat     = 1;
        while (!done32 && lat < 100) begin
            if (lat == 3) begin
                start32 = 1'b1; a32 = 32'h7F800000; b32 = 32'h00000000;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start32 = 1'b0;
        n_checks++;
        if (lat !== 17 || product32 !== 32'h40400000 || flags32 !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_start latency %0d product %h flags %b required 17 40400000 0000",
                     lat, product32, flags32);
        end
        n_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done32) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++; $display("FAIL busy_start_extra_done got %0d required 0", n_done);
        end
    endtask

    task automatic test_reset_mid();
        int n_done, lat, bb;
        logic [31:0] p;
        logic [3:0]  f;
        @(posedge clk); #1;
        start32 = 1'b1; a32 = 32'h3F800001; b32 = 32'h3FFFFFFE;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy32, done32, product32, flags32} !== 38'h0) begin
            n_fail++;
            $display("FAIL mid_reset busy %b done %b product %h flags %b required all 0",
                     busy32, done32, product32, flags32);
        end
        n_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done32) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++; $display("FAIL mid_reset_done got %0d required 0", n_done);
        end
        run32(32'h3F800001, 32'h3F800001, p, f, lat, bb);
        n_checks++;
        if ({p, f} !== {32'h3F800002, 4'b0001} || lat !== 17) begin
            n_fail++;
            $display("FAIL after_reset product %h flags %b latency %0d required 3F800002 0001 17", p, f, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]     x[3] = '{32'h40400000, 32'hC0A00000, 32'h3F000000};
        logic [31:0]     y[3] = '{32'h40400000, 32'h40000000, 32'h3F000000};
        logic [31:0]     p;
        logic [3:0]      f, ef;
        longint unsigned ep;
        bit              sp;
        int lat, bb;
        for (int i = 0; i < 3; i++) begin
            ref_mul(8, 23, 64'(x[i]), 64'(y[i]), ep, ef, sp);
            run32(x[i], y[i], p, f, lat, bb);
            n_checks++;
            if ({p, f} !== {ep[31:0], ef} || lat !== 17) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h/%b latency %0d required %h/%b 17", i, p, f, lat, ep[31:0], ef);
            end
        end
    endtask

    task automatic test_half(input int count);
        logic [15:0]     x, y, p;
        logic [3:0]      f, ef;
        longint unsigned ep;
        bit              sp;
        int lat, bb;
        run16(16'h3E00, 16'h4000, p, f, lat, bb);
        n_checks++;
        if ({p, f} !== {16'h4200, 4'b0000} || lat !== 10 || bb !== 0) begin
            n_fail++; $display("FAIL half_basic got %h/%b latency %0d required 4200/0000 10", p, f, lat);
        end
        run16(16'h7BFF, 16'h7BFF, p, f, lat, bb);
        n_checks++;
        if ({p, f} !== {16'h7C00, 4'b0101}) begin
            n_fail++; $display("FAIL half_overflow got %h/%b required 7C00/0101", p, f);
        end
        for (int i = 0; i < count; i++) begin
            x = 16'(rand_op(5, 10));
            y = 16'(rand_op(5, 10));
            ref_mul(5, 10, 64'(x), 64'(y), ep, ef, sp);
            run16(x, y, p, f, lat, bb);
            n_checks++;
            if ({p, f} !== {ep[15:0], ef} || lat !== (sp ? 2 : 10) || bb !== 0) begin
                n_fail++;
                $display("FAIL rand16 a=%h b=%h got %h/%b lat %0d required %h/%b lat %0d",
                         x, y, p, f, lat, ep[15:0], ef, sp ? 2 : 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_random32(200);
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        test_half(150);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
